// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the PC / instruction-fetch sequencer.
package pc_fetch_pkg;

    localparam int unsigned DEF_PC_WIDTH     = 16;
    localparam int unsigned DEF_OFFSET_WIDTH = 9;
    localparam int unsigned IR_WIDTH         = 16;
    localparam logic [15:0] DEF_RESET_PC     = 16'h3000;
    localparam logic [IR_WIDTH-1:0] NOP      = 16'h0000;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StFetch   = 2'b01,
        StDecode  = 2'b10,
        StResolve = 2'b11
    } state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control, instruction-memory and decoder signals of the fetch unit.
interface pc_fetch_unit_if
    import pc_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = DEF_PC_WIDTH,
    parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH
);
    logic                    pc_ctl_0_in;
    logic                    pc_ctl_1_in;
    logic [OFFSET_WIDTH-1:0] offset_in;
    logic [PC_WIDTH-1:0]     jmp_base_in;
    logic                    halt_in;
    logic                    imem_ack_in;
    logic [IR_WIDTH-1:0]     imem_data_in;
    logic                    ir_ready_in;
    logic                    imem_req_out;
    logic [PC_WIDTH-1:0]     imem_addr_out;
    logic [IR_WIDTH-1:0]     ir_out;
    logic                    ir_valid_out;
    logic [PC_WIDTH-1:0]     pc_out;
    logic                    redirect_out;
    logic [1:0]              state_out;

    modport master (
        input  pc_ctl_0_in, pc_ctl_1_in, offset_in, jmp_base_in, halt_in,
        input  imem_ack_in, imem_data_in, ir_ready_in,
        output imem_req_out, imem_addr_out, ir_out, ir_valid_out, pc_out,
        output redirect_out, state_out
    );

    modport slave (
        output pc_ctl_0_in, pc_ctl_1_in, offset_in, jmp_base_in, halt_in,
        output imem_ack_in, imem_data_in, ir_ready_in,
        input  imem_req_out, imem_addr_out, ir_out, ir_valid_out, pc_out,
        input  redirect_out, state_out
    );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational redirect target: jump base, PC-relative branch, or hold.
module pc_next_logic
    import pc_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = DEF_PC_WIDTH,
    parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
    input  logic [PC_WIDTH-1:0]     i_pc,
    input  logic                    i_br_taken,
    input  logic                    i_jmp_sel,
    input  logic [OFFSET_WIDTH-1:0] i_offset,
    input  logic [PC_WIDTH-1:0]     i_jmp_base,
    output logic [PC_WIDTH-1:0]     o_next_pc,
    output logic                    o_load
);

    logic [PC_WIDTH-1:0] w_offset_sext;

    assign w_offset_sext = {{(PC_WIDTH - OFFSET_WIDTH){i_offset[OFFSET_WIDTH-1]}}, i_offset};

    // Jump wins over branch when both are asserted.
    always_comb begin
        o_next_pc = i_pc;
        o_load    = 1'b0;
        if (i_jmp_sel) begin
            o_next_pc = i_jmp_base;
            o_load    = 1'b1;
        end else if (i_br_taken) begin
            o_next_pc = i_pc + w_offset_sext;
            o_load    = 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Holds the architectural PC and sequences fetch -> decode handoff -> branch resolve.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH     = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = DEF_RESET_PC,
    parameter int unsigned         OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
    input logic            clka,
    input logic            reset_in,
    pc_fetch_unit_if.master bus
);

    state_e               r_state;
    state_e               w_state_next;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  w_pc_next;
    logic [IR_WIDTH-1:0]  r_ir;
    logic [IR_WIDTH-1:0]  w_ir_next;
    logic                 r_redirect;
    logic                 w_redirect_next;
    logic [PC_WIDTH-1:0]  w_br_pc;
    logic                 w_br_load;

    pc_next_logic #(
        .PC_WIDTH    (PC_WIDTH),
        .OFFSET_WIDTH(OFFSET_WIDTH)
    ) u_pc_next_logic (
        .i_pc      (r_pc),
        .i_br_taken(bus.pc_ctl_0_in),
        .i_jmp_sel (bus.pc_ctl_1_in),
        .i_offset  (bus.offset_in),
        .i_jmp_base(bus.jmp_base_in),
        .o_next_pc (w_br_pc),
        .o_load    (w_br_load)
    );

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_redirect_next = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!bus.halt_in) w_state_next = StFetch;
            end
            StFetch: begin
                if (bus.imem_ack_in) begin
                    w_ir_next    = bus.imem_data_in;
                    w_pc_next    = r_pc + PC_WIDTH'(1);
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (bus.ir_ready_in) w_state_next = StResolve;
            end
            StResolve: begin
                w_pc_next       = w_br_pc;
                w_redirect_next = w_br_load;
                w_state_next    = bus.halt_in ? StIdle : StFetch;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset_in) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_ir       <= NOP;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_redirect <= w_redirect_next;
        end
    end

    assign bus.imem_req_out  = (r_state == StFetch);
    assign bus.imem_addr_out = (r_state == StFetch) ? r_pc : '0;
    assign bus.ir_out        = r_ir;
    assign bus.ir_valid_out  = (r_state == StDecode);
    assign bus.pc_out        = r_pc;
    assign bus.redirect_out  = r_redirect;
    assign bus.state_out     = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit against an instruction-level PC model.
module tb_pc_fetch_unit;

    logic        clka = 1'b0;
    logic        reset_in;
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_pc;

    always #5 clka = ~clka;

    pc_fetch_unit_if #(.PC_WIDTH(16), .OFFSET_WIDTH(9)) bus ();

    pc_fetch_unit #(
        .PC_WIDTH    (16),
        .RESET_PC    (16'h3000),
        .OFFSET_WIDTH(9)
    ) dut (
        .clka    (clka),
        .reset_in(reset_in),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // One instruction, entered with the DUT sampled in FETCH.
    task automatic run_instr(input logic [15:0] data, input int ack_dly, input int rdy_dly,
                             input logic c0, input logic c1, input logic [8:0] off,
                             input logic [15:0] base, input logic halt);
        logic [15:0] exp_pc;
        logic        exp_load;
        int          t;
        bus.pc_ctl_0_in = 1'($urandom_range(0, 1));
        bus.pc_ctl_1_in = 1'($urandom_range(0, 1));
        bus.offset_in   = 9'($urandom);
        bus.jmp_base_in = 16'($urandom);
        total++;
        if (bus.state_out !== 2'b01 || bus.imem_req_out !== 1'b1 || bus.imem_addr_out !== m_pc) begin
            bad++;
            $display("FAIL fetch_entry: state=%0d req=%b addr=%h, required state=1 req=1 addr=%h",
                     bus.state_out, bus.imem_req_out, bus.imem_addr_out, m_pc);
        end
        for (int i = 0; i < ack_dly; i++) begin
            bus.imem_ack_in  = 1'b0;
            bus.imem_data_in = 16'($urandom);
            bus.halt_in      = 1'($urandom_range(0, 1));
            step();
            total++;
            if (bus.state_out !== 2'b01 || bus.imem_req_out !== 1'b1 ||
                bus.imem_addr_out !== m_pc || bus.pc_out !== m_pc) begin
                bad++;
                $display("FAIL fetch_stall: state=%0d req=%b addr=%h pc=%h, required 1 1 %h %h",
                         bus.state_out, bus.imem_req_out, bus.imem_addr_out, bus.pc_out, m_pc, m_pc);
            end
        end
        bus.imem_ack_in  = 1'b1;
        bus.imem_data_in = data;
        step();
        bus.imem_ack_in  = 1'b0;
        m_pc = m_pc + 16'd1;
        total++;
        if (bus.state_out !== 2'b10 || bus.ir_valid_out !== 1'b1 || bus.ir_out !== data ||
            bus.pc_out !== m_pc || bus.imem_req_out !== 1'b0 || bus.imem_addr_out !== 16'h0 ||
            bus.redirect_out !== 1'b0) begin
            bad++;
            $display("FAIL decode_entry: state=%0d valid=%b ir=%h pc=%h req=%b addr=%h redir=%b, required 2 1 %h %h 0 0000 0",
                     bus.state_out, bus.ir_valid_out, bus.ir_out, bus.pc_out, bus.imem_req_out,
                     bus.imem_addr_out, bus.redirect_out, data, m_pc);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            bus.ir_ready_in = 1'b0;
            bus.halt_in     = 1'($urandom_range(0, 1));
            step();
            total++;
            if (bus.state_out !== 2'b10 || bus.ir_valid_out !== 1'b1 || bus.ir_out !== data ||
                bus.pc_out !== m_pc) begin
                bad++;
                $display("FAIL decode_stall: state=%0d valid=%b ir=%h pc=%h, required 2 1 %h %h",
                         bus.state_out, bus.ir_valid_out, bus.ir_out, bus.pc_out, data, m_pc);
            end
        end
        bus.ir_ready_in = 1'b1;
        step();
        bus.ir_ready_in = 1'b0;
        total++;
        if (bus.state_out !== 2'b11 || bus.ir_valid_out !== 1'b0 || bus.imem_req_out !== 1'b0) begin
            bad++;
            $display("FAIL resolve_entry: state=%0d valid=%b req=%b, required 3 0 0",
                     bus.state_out, bus.ir_valid_out, bus.imem_req_out);
        end
        bus.pc_ctl_0_in = c0;
        bus.pc_ctl_1_in = c1;
        bus.offset_in   = off;
        bus.jmp_base_in = base;
        bus.halt_in     = halt;
        step();
        exp_load = c1 | c0;
        exp_pc   = m_pc;
        if (c1) begin
            exp_pc = base;
        end else if (c0) begin
            t      = int'(m_pc) + int'($signed(off));
            exp_pc = t[15:0];
        end
        m_pc = exp_pc;
        total++;
        if (bus.redirect_out !== exp_load || bus.pc_out !== m_pc ||
            bus.state_out !== (halt ? 2'b00 : 2'b01)) begin
            bad++;
            $display("FAIL resolve_update: redir=%b pc=%h state=%0d, required %b %h %0d",
                     bus.redirect_out, bus.pc_out, bus.state_out, exp_load, m_pc, halt ? 0 : 1);
        end
        bus.pc_ctl_0_in = 1'($urandom_range(0, 1));
        bus.pc_ctl_1_in = 1'($urandom_range(0, 1));
        if (halt) begin
            for (int i = 0; i < 2; i++) begin
                step();
                total++;
                if (bus.state_out !== 2'b00 || bus.imem_req_out !== 1'b0 ||
                    bus.imem_addr_out !== 16'h0 || bus.redirect_out !== 1'b0 ||
                    bus.pc_out !== m_pc) begin
                    bad++;
                    $display("FAIL halt_park: state=%0d req=%b addr=%h redir=%b pc=%h, required 0 0 0000 0 %h",
                             bus.state_out, bus.imem_req_out, bus.imem_addr_out,
                             bus.redirect_out, bus.pc_out, m_pc);
                end
            end
            bus.halt_in = 1'b0;
            step();
        end else begin
            bus.halt_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        reset_in         = 1'b1;
        bus.imem_ack_in  = 1'b1;
        bus.imem_data_in = 16'hA5A5;
        step();
        step();
        total++;
        if (bus.state_out !== 2'b00 || bus.imem_req_out !== 1'b0 || bus.imem_addr_out !== 16'h0 ||
            bus.ir_out !== 16'h0 || bus.ir_valid_out !== 1'b0 || bus.redirect_out !== 1'b0 ||
            bus.pc_out !== 16'h3000) begin
            bad++;
            $display("FAIL reset_state: state=%0d req=%b addr=%h ir=%h valid=%b redir=%b pc=%h, required 0 0 0000 0000 0 0 3000",
                     bus.state_out, bus.imem_req_out, bus.imem_addr_out, bus.ir_out,
                     bus.ir_valid_out, bus.redirect_out, bus.pc_out);
        end
        reset_in        = 1'b0;
        bus.halt_in     = 1'b0;
        bus.imem_ack_in = 1'b0;
        step();
        m_pc = 16'h3000;
    endtask

    task automatic test_basic_branch();
        run_instr(16'h1234, 0, 0, 1'b1, 1'b0, 9'h1FE, 16'h5555, 1'b0);
        total++;
        if (bus.imem_addr_out !== 16'h2FFF) begin
            bad++;
            $display("FAIL branch_back_target: addr=%h, required 2fff", bus.imem_addr_out);
        end
    endtask

    task automatic test_jump_priority();
        run_instr(16'($urandom), 0, 0, 1'b1, 1'b1, 9'h005, 16'h4000, 1'b0);
        total++;
        if (bus.imem_addr_out !== 16'h4000 || bus.redirect_out !== 1'b1) begin
            bad++;
            $display("FAIL jump_priority: addr=%h redir=%b, required 4000 1",
                     bus.imem_addr_out, bus.redirect_out);
        end
    endtask

    task automatic test_wrap();
        run_instr(16'($urandom), 0, 0, 1'b0, 1'b1, 9'h000, 16'hFFFF, 1'b0);
        run_instr(16'h0F0F, 0, 0, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b0);
        total++;
        if (bus.pc_out !== 16'h0000 || bus.imem_addr_out !== 16'h0000 || bus.redirect_out !== 1'b0) begin
            bad++;
            $display("FAIL pc_wrap: pc=%h addr=%h redir=%b, required 0000 0000 0",
                     bus.pc_out, bus.imem_addr_out, bus.redirect_out);
        end
    endtask

    task automatic test_stalls();
        run_instr(16'hC3C3, 5, 3, 1'b0, 1'b0, 9'h0, 16'h0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        bus.imem_ack_in = 1'b0;
        step();
        step();
        reset_in = 1'b1;
        step();
        total++;
        if (bus.state_out !== 2'b00 || bus.imem_req_out !== 1'b0 || bus.pc_out !== 16'h3000 ||
            bus.ir_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_fetch: state=%0d req=%b pc=%h ir=%h, required 0 0 3000 0000",
                     bus.state_out, bus.imem_req_out, bus.pc_out, bus.ir_out);
        end
        reset_in         = 1'b0;
        bus.halt_in      = 1'b0;
        bus.imem_ack_in  = 1'b1;
        bus.imem_data_in = 16'hBEEF;
        step();
        bus.imem_ack_in = 1'b0;
        m_pc = 16'h3000;
        total++;
        if (bus.state_out !== 2'b01 || bus.ir_out !== 16'h0 || bus.imem_addr_out !== 16'h3000) begin
            bad++;
            $display("FAIL idle_ack_ignored: state=%0d ir=%h addr=%h, required 1 0000 3000",
                     bus.state_out, bus.ir_out, bus.imem_addr_out);
        end
    endtask

    task automatic test_halt();
        run_instr(16'h7777, 1, 1, 1'b1, 1'b0, 9'h010, 16'h0, 1'b1);
        run_instr(16'h8888, 0, 0, 1'b0, 1'b0, 9'h0, 16'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      9'($urandom), 16'($urandom), 1'($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_in         = 1'b1;
        bus.pc_ctl_0_in  = 1'b0;
        bus.pc_ctl_1_in  = 1'b0;
        bus.offset_in    = '0;
        bus.jmp_base_in  = '0;
        bus.halt_in      = 1'b0;
        bus.imem_ack_in  = 1'b0;
        bus.imem_data_in = '0;
        bus.ir_ready_in  = 1'b0;
        m_pc             = 16'h3000;
        test_reset();
        test_basic_branch();
        test_jump_priority();
        test_wrap();
        test_stalls();
        test_reset_mid_fetch();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer that sits directly downstream of ALU_FSM.
- Consumes ALU_FSM's branch decision (pc_ctl_0_out) plus a jump select from the decoder, and holds the architectural PC.
- Runs the instruction-memory request/acknowledge handshake and presents the fetched instruction to the decoder, which drives ALU_FSM's n/z/p_dec_in and br_in.

Parameters:
- PC_WIDTH, 16, width of PC, addresses and jump base.
- RESET_PC, 16'h3000, PC value loaded on reset.
- OFFSET_WIDTH, 9, width of the signed PC-relative branch offset.

Ports:
- clka  in  1  single system clock; all state updates on its rising edge.
- reset_in  in  1  synchronous, active-high reset.
- pc_ctl_0_in  in  1  branch taken, driven by ALU_FSM pc_ctl_0_out.
- pc_ctl_1_in  in  1  unconditional jump select (JMP/RET), from decoder.
- offset_in  in  OFFSET_WIDTH  signed branch offset from IR.
- jmp_base_in  in  PC_WIDTH  jump target from register file.
- halt_in  in  1  request to stop fetching.
- imem_ack_in  in  1  instruction memory data valid.
- imem_data_in  in  16  fetched instruction word.
- ir_ready_in  in  1  decoder accepts the IR.
- imem_req_out  out  1  fetch request.
- imem_addr_out  out  PC_WIDTH  fetch address.
- ir_out  out  16  instruction register.
- ir_valid_out  out  1  IR holds an unconsumed instruction.
- pc_out  out  PC_WIDTH  current PC, already incremented past the fetched instruction.
- redirect_out  out  1  one-cycle pulse when PC is redirected.
- state_out  out  2  FSM state, debug.

Behaviour:
- Reset (synchronous, active-high): on any clka edge with reset_in=1, regardless of state:
  - state=IDLE, pc=RESET_PC, ir=16'h0000.
  - imem_req_out=0, ir_valid_out=0, redirect_out=0.
- A fetch in flight at reset is abandoned; an imem_ack_in arriving in IDLE is ignored.
- State encodings: IDLE=2'b00, FETCH=2'b01, DECODE=2'b10, RESOLVE=2'b11. state_out equals the current state.
- IDLE:
  - All outputs are inactive.
  - Go to FETCH next cycle if halt_in=0; otherwise remain in IDLE.
- FETCH:
  - imem_req_out=1 and imem_addr_out=pc, held stable until ack.
  - On imem_ack_in=1: ir<=imem_data_in, pc<=pc+1 (modulo 2^PC_WIDTH, so 16'hFFFF wraps to 16'h0000), go to DECODE.
  - halt_in is ignored in FETCH; the bus transaction always completes.
- DECODE:
  - ir_valid_out=1.
  - On ir_ready_in=1, go to RESOLVE; otherwise hold ir and pc unchanged.
- RESOLVE (exactly one cycle): sample pc_ctl_1_in and pc_ctl_0_in, then update pc:
  - If pc_ctl_1_in=1: pc<=jmp_base_in. Jump has priority when both controls are high.
  - Else if pc_ctl_0_in=1: pc<=pc+sign_extend(offset_in), modular, so wrap in either direction is allowed.
  - Else pc is unchanged.
  - redirect_out=1 in the cycle following RESOLVE if and only if pc was loaded.
  - Next state is IDLE if halt_in=1, else FETCH.
- Branch latency: the next imem_addr_out after a taken branch is the target, with no wrong-path fetch. The minimum instruction period is 3 cycles (FETCH with same-cycle ack, then DECODE, then RESOLVE).
- imem_addr_out is 0 whenever imem_req_out=0.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package pc_fetch_pkg holds:
  - the state encodings;
  - defaults for RESET_PC, PC_WIDTH and OFFSET_WIDTH;
  - an NOP encoding constant, 16'h0000, used for the IR reset value.
- One sub-module, pc_next_logic: combinational next-PC mux and adder. Inputs are pc, the two controls, offset and jmp_base; outputs are next_pc and a load flag. Sign extension lives here.

Test Plan:
- Reset then release, imem_ack_in=1 every request with data 16'h1234 → first imem_addr_out=16'h3000; ir_out=16'h1234; pc_out=16'h3001; state sequence IDLE, FETCH, DECODE.
- In RESOLVE, pc_ctl_0_in=1 with offset_in=9'h1FE (−2) and pc=16'h3001 → next imem_addr_out=16'h2FFF; redirect_out pulses once.
- pc_ctl_0_in=1 and pc_ctl_1_in=1 together, jmp_base_in=16'h4000 → next fetch address is 16'h4000, confirming jump priority.
- Fetch at pc=16'hFFFF with no branch → pc_out=16'h0000 and the next fetch address is 16'h0000.
- imem_ack_in held low for 5 cycles, then ir_ready_in low for 3 cycles → imem_req_out stays high with a stable address, then ir_valid_out stays high with a stable ir_out; pc does not move.
- reset_in=1 mid-FETCH → next cycle state_out=2'b00, imem_req_out=0, pc_out=16'h3000. Also halt_in=1 in RESOLVE → FSM parks in IDLE with no request until halt_in drops.
